// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states, iteration count.
// Optional feature macro used by muldiv_unit: MULDIV_FAST_MUL_EN (single-cycle multiply).
package muldiv_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned MULDIV_ITERS = 32;
  localparam int unsigned CNT_W        = 5;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational two's-complement conditional negate: two 32-bit lanes and one 64-bit lane.
// Used for operand magnitudes at start and for result sign correction in FIX.
module muldiv_signfix (
  input  logic [31:0] x_in,
  input  logic        x_neg,
  output logic [31:0] x_out,
  input  logic [31:0] y_in,
  input  logic        y_neg,
  output logic [31:0] y_out,
  input  logic [63:0] w_in,
  input  logic        w_neg,
  output logic [63:0] w_out
);

  assign x_out = x_neg ? (~x_in + 32'd1) : x_in;
  assign y_out = y_neg ? (~y_in + 32'd1) : y_in;
  assign w_out = w_neg ? (~w_in + 64'd1) : w_in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply; division stays iterative.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef MULDIV_FAST_MUL_EN
  localparam state_t MUL_ENTRY = ST_FIX;
`else
  localparam state_t MUL_ENTRY = ST_MUL;
`endif

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [2*XLEN-1:0]  acc;
  logic [XLEN-1:0]    mcand;
  logic               sign_a, sign_b, is_div, div0;
  logic               busy_nx, done_nx;

  logic               accept, is_mul_op, is_div_op, signed_start, fix;
  logic [XLEN:0]      mul_sum, div_shift, div_diff;
  logic               div_qbit;
  logic [XLEN-1:0]    div_rem;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    x_in, x_out, y_in, y_out;
  logic               x_neg, y_neg;
  logic [2*XLEN-1:0]  w_out;

  assign accept       = (state == ST_IDLE) && start && !flush;
  assign is_mul_op    = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op    = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_start = is_signed_op(op);
  assign fix          = (state == ST_FIX);

  // One shift-add step: low half of acc holds the remaining multiplier bits
  assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mcand : 32'd0)};

  // One restoring-divide step: remainder in acc[63:32], dividend/quotient in acc[31:0]
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = div_shift - {1'b0, mcand};
  assign div_qbit  = ~div_diff[32];
  assign div_rem   = div_qbit ? div_diff[31:0] : div_shift[31:0];

`ifdef MULDIV_FAST_MUL_EN
  assign prod = 64'(mcand) * 64'(acc[31:0]);
`else
  assign prod = acc;
`endif

  // Lanes take operands in IDLE and quotient/remainder in FIX; divide-by-zero skips quotient fix-up
  assign x_in  = fix ? acc[31:0] : a;
  assign x_neg = fix ? ((sign_a ^ sign_b) & ~div0) : (signed_start & a[31]);
  assign y_in  = fix ? acc[63:32] : b;
  assign y_neg = fix ? sign_a : (signed_start & b[31]);

  muldiv_signfix u_signfix (
    .x_in  (x_in),
    .x_neg (x_neg),
    .x_out (x_out),
    .y_in  (y_in),
    .y_neg (y_neg),
    .y_out (y_out),
    .w_in  (prod),
    .w_neg (sign_a ^ sign_b),
    .w_out (w_out)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept && is_mul_op)      state_nx = MUL_ENTRY;
        else if (accept && is_div_op) state_nx = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (flush)                                      state_nx = ST_IDLE;
        else if (cnt == CNT_W'(MULDIV_ITERS - 1))       state_nx = ST_FIX;
      end
      ST_FIX:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output next-values, registered below
  always_comb begin
    busy_nx = 1'b0;
    done_nx = 1'b0;
    busy_nx = (state_nx != ST_IDLE);
    done_nx = fix && !flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  // Datapath and HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (accept) begin
            sign_a <= signed_start & a[31];
            sign_b <= signed_start & b[31];
            if (is_mul_op) begin
              acc    <= {32'd0, y_out};
              mcand  <= x_out;
              is_div <= 1'b0;
              div0   <= 1'b0;
            end else if (is_div_op) begin
              acc    <= {32'd0, x_out};
              mcand  <= y_out;
              is_div <= 1'b1;
              div0   <= (b == 32'd0);
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        ST_MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + CNT_W'(1);
        end
        ST_DIV: begin
          acc <= {div_rem, acc[30:0], div_qbit};
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          if (!flush) begin
            if (is_div) begin
              hi <= y_out;
              lo <= x_out;
            end else begin
              hi <= w_out[63:32];
              lo <= w_out[31:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = OP_NONE;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total  = 0;
  int passed = 0;

  muldiv_unit dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else             passed++;
  endtask

  // Present a one-cycle start; returns 1 time unit after the sampling edge E0
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; op = OP_NONE;
  endtask

  // Wait (bounded) for done; flags any HI/LO movement before done
  task automatic wait_done(output int n, output bit moved);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; n = 0; moved = 1'b0;
    while (!done && n < 100) begin
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int n; bit moved;
    issue(o, x, y);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(n, moved);
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_hold"}, 64'(moved), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n, pre; bit moved, seen;
    logic [31:0] h_prev, l_prev;

    #2 rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk) rst = 1'b1;

    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, MUL_LAT);
    run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, MUL_LAT);
    run_op("mult_nn", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, MUL_LAT);
    run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT);
    run_op("div_negb", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DIV_LAT);
    run_op("divu_zero", OP_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, DIV_LAT);
    run_op("div_zero_neg", OP_DIV, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, DIV_LAT);
    run_op("div_wrap", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DIV_LAT);

    // Zero-latency moves
    issue(OP_MTHI, 32'h12345678, 32'd0);
    check("mthi_hi", 64'(hi), 64'h12345678);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    issue(OP_MTLO, 32'hCAFEF00D, 32'd0);
    check("mtlo_lo", 64'(lo), 64'hCAFEF00D);

    // Starts while busy are ignored
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    issue(OP_MTHI, 32'h0000DEAD, 32'd0);
    check("busy_mthi_hi", 64'(hi), 64'h12345678);
    check("busy_mthi_busy", 64'(busy), 64'd1);
    issue(OP_MULT, 32'd2, 32'd3);
    check("busy_mult_busy", 64'(busy), 64'd1);
    pre = 5;
    wait_done(n, moved);
    check("busy_ign_lat", 64'(pre + n), 64'(DIV_LAT));
    check("busy_ign_hi", 64'(hi), 64'd2);
    check("busy_ign_lo", 64'(lo), 64'd14);
    @(posedge clk); #1;

    // Flush mid-divide at E10
    h_prev = hi; l_prev = lo;
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_hi", 64'(hi), 64'(h_prev));
    check("flush_lo", 64'(lo), 64'(l_prev));

    // Flush beats start in IDLE
    @(negedge clk);
    start = 1'b1; op = OP_MTLO; a = 32'h55AA55AA; flush = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0; op = OP_NONE;
    check("flush_start_lo", 64'(lo), 64'(l_prev));
    check("flush_start_busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-multiply
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (14) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk) rst = 1'b1;
    run_op("post_rst", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, MUL_LAT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers, sitting beside the execute stage of the five-stage MIPS pipeline. It accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO from the ID/EX boundary and computes over multiple cycles. Busy status goes back to hazard control so MFHI/MFLO stall until results land. HI/LO are read combinationally by execute.

## Interface
- No parameters; width fixed at 32.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only when idle
- op  input  3  operation code from muldiv_pkg
- a  input  32  rs operand: multiplicand or dividend; also MTHI/MTLO data
- b  input  32  rt operand: multiplier or divisor
- flush  input  1  abort the in-flight operation
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO receive a mul/div result
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- **Op encoding:**
  - 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - Codes 0 and 7 are no-ops.
- **States:** IDLE, MUL, DIV, FIX.
- **Start rules:**
  - Start is ignored unless the state is IDLE.
  - Start with MTHI/MTLO writes `a` into hi/lo at that edge. It does not assert busy or done.
- **Signed ops:**
  - Operands are converted to magnitudes at start; the sign flags are latched.
  - MULT: the 64-bit product is negated in FIX if the signs differ.
  - DIV: the quotient is negated if the signs differ. The remainder takes the dividend's sign.
- **MUL:** shift-add, one multiplier bit per cycle, 32 cycles, 64-bit accumulator.
- **DIV:** restoring division, one quotient bit per cycle, 32 cycles.
- **FIX:**
  - Applies sign correction.
  - Writes hi = product[63:32] / remainder and lo = product[31:0] / quotient.
  - Pulses done and returns to IDLE.
- **Divide by zero (b == 0):** takes the normal latency and produces lo = 0xFFFFFFFF, hi = `a` as given. No sign fix-up is applied.
- **DIV 0x80000000 / 0xFFFFFFFF:** lo = 0x80000000, hi = 0. This is the natural wrap; no trap.
- **Flush:**
  - In any non-IDLE state, flush returns to IDLE at the next edge.
  - hi/lo are unchanged and done is not pulsed.
  - If flush and start arrive together in IDLE, flush wins and the start is dropped.
- **Reset:** async to IDLE. busy = 0, done = 0, hi = 0, lo = 0. Reset mid-operation discards the operation.

## Timing
- Start is sampled at edge E0.
- busy is high from after E0 until after E33.
- Iterations run on edges E1–E32. FIX is at E33.
- hi/lo are valid and done = 1 during the cycle following E33; busy = 0 in that cycle.
- A new start is accepted at the edge that ends the done cycle; back-to-back throughput is 34 cycles.
- MTHI/MTLO have zero latency: the new value is visible on hi/lo after E0.
- hi/lo hold their value between writes and never change while busy, except under reset.

## Configuration
- **MULDIV_FAST_MUL_EN defined:**
  - MULT/MULTU use a single-cycle combinational 32x32 product.
  - State goes IDLE → FIX at E1.
  - done pulses after E1; busy is high for exactly one cycle.
  - Division is unchanged.
- **Undefined:** multiplication is iterative, with the 33-edge latency above.

## Structure
- muldiv_pkg holds:
  - the op code constants;
  - the state encoding;
  - the iteration count constant MULDIV_ITERS = 32.
- One sub-module, muldiv_signfix: combinational two's-complement abs/negate for 32- and 64-bit values, used at start and in FIX.

## Test plan
- MULTU a=0xFFFFFFFF, b=2 → after E33: hi=0x00000001, lo=0xFFFFFFFE; done pulse exactly once.
- MULT a=-3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. With MULDIV_FAST_MUL_EN, the same result is produced after E1.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007.
- MTHI a=0x12345678, then a second start with MULT while busy → hi=0x12345678 immediately. The second start is ignored; busy stays high until the original op completes.
- DIVU in flight, flush at E10 → busy=0 after E10, no done; hi/lo retain their prior values.
- rst low during MUL at E15 → busy, done, hi, lo all 0 immediately (asynchronous); after release, a fresh MULTU 3*4 gives lo=12, hi=0.
